// File: rtl/cnn_accel_pkg.sv
// Shared types and helpers for the CNN accelerator tile address generators.
// Holds the FSM state encoding, default feature-map geometry and the extent clip.
package cnn_accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } tile_state_e;

  localparam int PKG_M      = 256;
  localparam int PKG_R      = 128;
  localparam int PKG_C      = 128;
  localparam int CH_STRIDE  = PKG_R * PKG_C;
  localparam int ROW_STRIDE = PKG_C;

  // Number of elements a tile covers along one axis once clipped at the map edge.
  function automatic logic [31:0] min_ext(input logic [31:0] limit,
                                          input logic [31:0] base,
                                          input logic [31:0] tile);
    if (base >= limit) begin
      return '0;
    end else if ((limit - base) < tile) begin
      return limit - base;
    end else begin
      return tile;
    end
  endfunction

endpackage

// File: rtl/in_fm_tile_rd_gen_if.sv
// DMA read-request channel: valid/ready handshake carrying a burst address and length.
interface in_fm_tile_rd_gen_if #(
  parameter int AW = 16,
  parameter int LW = 8
);
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [LW-1:0] rd_req_len;

  modport master (
    output rd_req_valid,
    output rd_req_addr,
    output rd_req_len,
    input  rd_req_ready
  );

  modport slave (
    input  rd_req_valid,
    input  rd_req_addr,
    input  rd_req_len,
    output rd_req_ready
  );
endinterface

// File: rtl/tile_extent_calc.sv
// Combinational clip of a tile against the feature-map bounds plus its first word address.
// Shared between the input-tile read generator and the output-tile store generator.
module tile_extent_calc
  import cnn_accel_pkg::*;
#(
  parameter int AW      = 16,
  parameter int LW      = 8,
  parameter int M       = PKG_M,
  parameter int R       = PKG_R,
  parameter int C       = PKG_C,
  parameter int Tm      = 16,
  parameter int Tr      = 64,
  parameter int Tc      = 16,
  parameter int FM_BASE = 0
) (
  input  logic [AW-1:0] base_m_i,
  input  logic [AW-1:0] base_row_i,
  input  logic [AW-1:0] base_col_i,
  output logic [AW-1:0] ch_ext_o,
  output logic [AW-1:0] row_ext_o,
  output logic [LW-1:0] len_o,
  output logic [AW-1:0] start_addr_o
);

  assign ch_ext_o  = AW'(min_ext(32'(M), 32'(base_m_i),   32'(Tm)));
  assign row_ext_o = AW'(min_ext(32'(R), 32'(base_row_i), 32'(Tr)));
  assign len_o     = LW'(min_ext(32'(C), 32'(base_col_i), 32'(Tc)));

  // Everything is evaluated at AW bits so the address wraps modulo 2^AW.
  assign start_addr_o = AW'(FM_BASE) + base_m_i * AW'(R * C)
                      + base_row_i * AW'(C) + base_col_i;

endmodule

// File: rtl/in_fm_tile_rd_gen.sv
// Issues one DDR burst read per (channel, row) of an input-feature-map tile,
// channel-major with rows inner, using stride accumulators only.
module in_fm_tile_rd_gen
  import cnn_accel_pkg::*;
#(
  parameter int AW      = 16,
  parameter int LW      = 8,
  parameter int M       = PKG_M,
  parameter int R       = PKG_R,
  parameter int C       = PKG_C,
  parameter int Tm      = 16,
  parameter int Tr      = 64,
  parameter int Tc      = 16,
  parameter int FM_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     tile_base_m,
  input  logic [AW-1:0]     tile_base_row,
  input  logic [AW-1:0]     tile_base_col,
  in_fm_tile_rd_gen_if.master rd,
  output logic              busy,
  output logic              done
);

  localparam logic [AW-1:0] CH_STEP  = AW'(R * C);
  localparam logic [AW-1:0] ROW_STEP = AW'(C);
  localparam logic [AW-1:0] ONE      = AW'(1);

  tile_state_e   state_q, state_d;
  logic          start_q, start_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] chan_base_q, chan_base_d;
  logic [AW-1:0] row_cnt_q, row_cnt_d;
  logic [AW-1:0] ch_cnt_q, ch_cnt_d;
  logic [AW-1:0] row_ext_q, row_ext_d;
  logic [AW-1:0] ch_ext_q, ch_ext_d;

  logic [AW-1:0] ext_ch, ext_row, ext_addr;
  logic [LW-1:0] ext_len;

  tile_extent_calc #(
    .AW(AW), .LW(LW), .M(M), .R(R), .C(C),
    .Tm(Tm), .Tr(Tr), .Tc(Tc), .FM_BASE(FM_BASE)
  ) u_extent (
    .base_m_i     (tile_base_m),
    .base_row_i   (tile_base_row),
    .base_col_i   (tile_base_col),
    .ch_ext_o     (ext_ch),
    .row_ext_o    (ext_row),
    .len_o        (ext_len),
    .start_addr_o (ext_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      chan_base_q <= '0;
      row_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      row_ext_q   <= '0;
      ch_ext_q    <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      chan_base_q <= chan_base_d;
      row_cnt_q   <= row_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      row_ext_q   <= row_ext_d;
      ch_ext_q    <= ch_ext_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    len_d       = len_q;
    chan_base_d = chan_base_q;
    row_cnt_d   = row_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    row_ext_d   = row_ext_q;
    ch_ext_d    = ch_ext_q;
    // start is registered once and only while idle, so pulses in any other state are dropped
    start_d     = start && (state_q == IDLE) && !start_q;

    unique case (state_q)
      IDLE: begin
        if (start_q) state_d = SETUP;
      end
      SETUP: begin
        ch_ext_d    = ext_ch;
        row_ext_d   = ext_row;
        len_d       = ext_len;
        addr_d      = ext_addr;
        chan_base_d = ext_addr;
        row_cnt_d   = '0;
        ch_cnt_d    = '0;
        if (ext_ch != '0 && ext_row != '0 && ext_len != '0) begin
          state_d = ISSUE;
          valid_d = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      ISSUE: begin
        if (valid_q && rd.rd_req_ready) begin
          if (row_cnt_q + ONE == row_ext_q) begin
            row_cnt_d = '0;
            if (ch_cnt_q + ONE == ch_ext_q) begin
              valid_d = 1'b0;
              state_d = DONE;
            end else begin
              ch_cnt_d    = ch_cnt_q + ONE;
              chan_base_d = chan_base_q + CH_STEP;
              addr_d      = chan_base_q + CH_STEP;
            end
          end else begin
            row_cnt_d = row_cnt_q + ONE;
            addr_d    = addr_q + ROW_STEP;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd.rd_req_valid = valid_q;
  assign rd.rd_req_addr  = addr_q;
  assign rd.rd_req_len   = len_q;
  assign busy            = start_q || (state_q != IDLE);
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_in_fm_tile_rd_gen.sv
// Scoreboard bench for the input-feature-map tile read generator on a small 4x6x10 map.
module tb_in_fm_tile_rd_gen;

  localparam int AW      = 16;
  localparam int LW      = 8;
  localparam int M       = 4;
  localparam int R       = 6;
  localparam int C       = 10;
  localparam int Tm      = 2;
  localparam int Tr      = 4;
  localparam int Tc      = 8;
  localparam int FM_BASE = 'h100;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } req_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] bm = '0;
  logic [AW-1:0] br = '0;
  logic [AW-1:0] bc = '0;
  logic          busy;
  logic          done;

  in_fm_tile_rd_gen_if #(.AW(AW), .LW(LW)) rd ();

  in_fm_tile_rd_gen #(
    .AW(AW), .LW(LW), .M(M), .R(R), .C(C),
    .Tm(Tm), .Tr(Tr), .Tc(Tc), .FM_BASE(FM_BASE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .tile_base_m   (bm),
    .tile_base_row (br),
    .tile_base_col (bc),
    .rd            (rd),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  req_t exp_q[$];
  req_t obs_q[$];

  int n_hs, first_valid, done_at, last_hs, stall_bad, done_cnt, valid_in_done, valid_after_done;

  // Reference model: clip the tile independently and list the bursts in issue order.
  task automatic push_expected(input int m, input int r, input int c);
    int   ce, re, ln;
    req_t e;
    ce = (m >= M) ? 0 : ((M - m < Tm) ? M - m : Tm);
    re = (r >= R) ? 0 : ((R - r < Tr) ? R - r : Tr);
    ln = (c >= C) ? 0 : ((C - c < Tc) ? C - c : Tc);
    if (ce != 0 && re != 0 && ln != 0) begin
      for (int ch = 0; ch < ce; ch++) begin
        for (int row = 0; row < re; row++) begin
          e.addr = AW'(FM_BASE + (m + ch) * R * C + (r + row) * C + c);
          e.len  = LW'(ln);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Drives one tile and records every handshake; cycle numbers count edges after start is sampled.
  task automatic run_tile(input int m, input int r, input int c, input int rdy_mode, input int inj_at);
    logic          pv, pr;
    logic [AW-1:0] pa;
    logic [LW-1:0] pl;
    req_t          o;
    pv = 1'b0; pr = 1'b0; pa = '0; pl = '0;
    n_hs = 0; first_valid = -1; done_at = -1; last_hs = -1;
    stall_bad = 0; done_cnt = 0; valid_in_done = 0; valid_after_done = 0;
    @(posedge clk); #1;
    bm = AW'(m); br = AW'(r); bc = AW'(c);
    start = 1'b1;
    rd.rd_req_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      rd.rd_req_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      start = (cyc == inj_at);
      @(negedge clk);
      if (pv && !pr && (rd.rd_req_valid !== 1'b1 || rd.rd_req_addr !== pa || rd.rd_req_len !== pl))
        stall_bad++;
      if (rd.rd_req_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (done_at >= 0 && rd.rd_req_valid === 1'b1) valid_after_done++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
        if (rd.rd_req_valid !== 1'b0) valid_in_done++;
      end
      if (rd.rd_req_valid === 1'b1 && rd.rd_req_ready === 1'b1) begin
        o.addr = rd.rd_req_addr;
        o.len  = rd.rd_req_len;
        obs_q.push_back(o);
        n_hs++;
        last_hs = cyc;
      end
      pv = rd.rd_req_valid; pr = rd.rd_req_ready; pa = rd.rd_req_addr; pl = rd.rd_req_len;
      @(posedge clk); #1;
      if (done_at >= 0 && cyc >= done_at + 4) break;
    end
    start = 1'b0;
    rd.rd_req_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd.rd_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (rd.rd_req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rd.rd_req_valid); end
    total++; if (rd.rd_req_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", rd.rd_req_addr); end
    total++; if (rd.rd_req_len !== '0) begin bad++; $display("FAIL reset_len got=%0d want=0", rd.rd_req_len); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    push_expected(0, 0, 0);
    run_tile(0, 0, 0, 0, -1);
    total++; if (n_hs !== 8) begin bad++; $display("FAIL basic_count got=%0d want=8", n_hs); end
    total++; if (first_valid !== 2) begin bad++; $display("FAIL basic_first_valid got=%0d want=2", first_valid); end
    total++; if (done_at !== 10) begin bad++; $display("FAIL basic_done_cycle got=%0d want=10", done_at); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
    total++; if (valid_in_done !== 0) begin bad++; $display("FAIL basic_valid_in_done got=%0d want=0", valid_in_done); end
    while (exp_q.size() > 0) begin
      req_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL basic_req missing want addr=%h len=%0d", e.addr, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL basic_req got addr=%h len=%0d want addr=%h len=%0d", o.addr, o.len, e.addr, e.len); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL basic_extra got=%0d want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_clip();
    push_expected(2, 4, 8);
    run_tile(2, 4, 8, 0, -1);
    total++; if (n_hs !== 4) begin bad++; $display("FAIL clip_count got=%0d want=4", n_hs); end
    total++; if (done_at !== last_hs + 1) begin bad++; $display("FAIL clip_done_cycle got=%0d want=%0d", done_at, last_hs + 1); end
    while (exp_q.size() > 0) begin
      req_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL clip_req missing want addr=%h len=%0d", e.addr, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL clip_req got addr=%h len=%0d want addr=%h len=%0d", o.addr, o.len, e.addr, e.len); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL clip_extra got=%0d want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_stall();
    push_expected(0, 0, 0);
    run_tile(0, 0, 0, 1, -1);
    total++; if (n_hs !== 8) begin bad++; $display("FAIL stall_count got=%0d want=8", n_hs); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL stall_hold got=%0d unstable cycles want=0", stall_bad); end
    total++; if (done_at !== last_hs + 1) begin bad++; $display("FAIL stall_done_cycle got=%0d want=%0d", done_at, last_hs + 1); end
    while (exp_q.size() > 0) begin
      req_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL stall_req missing want addr=%h len=%0d", e.addr, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL stall_req got addr=%h len=%0d want addr=%h len=%0d", o.addr, o.len, e.addr, e.len); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL stall_extra got=%0d want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_zero_extent();
    push_expected(4, 0, 0);
    run_tile(4, 0, 0, 0, -1);
    total++; if (n_hs !== 0) begin bad++; $display("FAIL zero_count got=%0d want=0", n_hs); end
    total++; if (first_valid !== -1) begin bad++; $display("FAIL zero_valid got first valid at %0d want none", first_valid); end
    total++; if (done_at !== 2) begin bad++; $display("FAIL zero_done_cycle got=%0d want=2", done_at); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_pulses got=%0d want=1", done_cnt); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL zero_model got=%0d want=0", exp_q.size()); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_start_ignored();
    push_expected(0, 0, 0);
    run_tile(0, 0, 0, 0, 4);
    total++; if (n_hs !== 8) begin bad++; $display("FAIL ignore_count got=%0d want=8", n_hs); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ignore_done_pulses got=%0d want=1", done_cnt); end
    total++; if (valid_after_done !== 0) begin bad++; $display("FAIL ignore_requeued got=%0d want=0", valid_after_done); end
    while (exp_q.size() > 0) begin
      req_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL ignore_req missing want addr=%h len=%0d", e.addr, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL ignore_req got addr=%h len=%0d want addr=%h len=%0d", o.addr, o.len, e.addr, e.len); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL ignore_extra got=%0d want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int hs, dn;
    hs = 0; dn = 0;
    @(posedge clk); #1;
    bm = '0; br = '0; bc = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rd.rd_req_ready = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (rd.rd_req_valid === 1'b1 && rd.rd_req_ready === 1'b1) hs++;
      @(posedge clk); #1;
      if (hs == 3) break;
    end
    total++; if (hs !== 3) begin bad++; $display("FAIL rstmid_handshakes got=%0d want=3", hs); end
    rst = 1'b1;
    #1;
    total++; if (rd.rd_req_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", rd.rd_req_valid); end
    total++; if (rd.rd_req_addr !== '0) begin bad++; $display("FAIL rstmid_addr got=%h want=0", rd.rd_req_addr); end
    total++; if (rd.rd_req_len !== '0) begin bad++; $display("FAIL rstmid_len got=%0d want=0", rd.rd_req_len); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done === 1'b1 || rd.rd_req_valid === 1'b1) dn++;
      @(posedge clk); #1;
    end
    rd.rd_req_ready = 1'b0;
    total++; if (dn !== 0) begin bad++; $display("FAIL rstmid_quiet got=%0d active cycles want=0", dn); end
    push_expected(0, 0, 0);
    run_tile(0, 0, 0, 0, -1);
    total++; if (n_hs !== 8) begin bad++; $display("FAIL rstmid_rerun_count got=%0d want=8", n_hs); end
    total++; if (first_valid !== 2) begin bad++; $display("FAIL rstmid_rerun_first got=%0d want=2", first_valid); end
    total++; if (done_at !== 10) begin bad++; $display("FAIL rstmid_rerun_done got=%0d want=10", done_at); end
    while (exp_q.size() > 0) begin
      req_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL rstmid_req missing want addr=%h len=%0d", e.addr, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL rstmid_req got addr=%h len=%0d want addr=%h len=%0d", o.addr, o.len, e.addr, e.len); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rstmid_extra got=%0d want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    rd.rd_req_ready = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_stall();
    test_zero_extent();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
